// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU command codes,
// request opcodes, sequencer states and word widths.
package alu_pkg;

  localparam int OP_W   = 3;   // request opcode width
  localparam int DATA_W = 15;  // request operand / result word width (ALU width)
  localparam int ALU_W  = 16;  // ALU operand port width ({operand, 1'b0})
  localparam int CMD_W  = 3;   // ALU command width

  // ALU command codes
  localparam logic [CMD_W-1:0] CMD_ADD = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SUB = 3'd1;
  localparam logic [CMD_W-1:0] CMD_AND = 3'd2;
  localparam logic [CMD_W-1:0] CMD_MP0 = 3'd3;
  localparam logic [CMD_W-1:0] CMD_MP1 = 3'd4;
  localparam logic [CMD_W-1:0] CMD_DV0 = 3'd5;
  localparam logic [CMD_W-1:0] CMD_DV1 = 3'd6;

  // Request opcodes; 5..7 are illegal
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } req_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE0 = 2'd1,
    ST_ISSUE1 = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Opcodes 0..4 are the only ones the ALU path understands
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return op <= OP_DIV;
  endfunction

  // The ALU computes D op C with C on alu_a; SUB and DIV need a on D
  function automatic logic op_swaps(input logic [OP_W-1:0] op);
    return (op == OP_SUB) || (op == OP_DIV);
  endfunction

  // First-phase ALU command for a legal opcode
  function automatic logic [CMD_W-1:0] op_to_cmd(input logic [OP_W-1:0] op);
    logic [CMD_W-1:0] cmd;
    case (op)
      OP_ADD:  cmd = CMD_ADD;
      OP_SUB:  cmd = CMD_SUB;
      OP_AND:  cmd = CMD_AND;
      OP_MUL:  cmd = CMD_MP0;
      OP_DIV:  cmd = CMD_DV0;
      default: cmd = CMD_ADD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake and ALU command/operand port of the sequencer.
// slave  = the sequencer itself
// master = the surrounding controller + ALU
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_lo;
  logic [DATA_W-1:0] rsp_hi;
  logic              rsp_err;

  logic [ALU_W-1:0]  alu_a;
  logic [ALU_W-1:0]  alu_b;
  logic [CMD_W-1:0]  alu_command;
  logic [DATA_W-1:0] alu_res;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_res,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err,
           alu_a, alu_b, alu_command
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_res,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err,
           alu_a, alu_b, alu_command
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts ADD/SUB/AND/MUL/DIV requests, drives the
// ALU command/operand port for one or two phases (MP0/MP1, DV0/DV1), captures
// the combinational result and returns a lo/hi/err response.
// Optional feature: define ALU_SEQ_PERF_EN to add perf_ops / perf_stall
// counters as extra outputs.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]     perf_ops,
  output logic [15:0]     perf_stall
`endif
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_lo_q, rsp_lo_d;
  logic [DATA_W-1:0] rsp_hi_q, rsp_hi_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ALU_W-1:0]  alu_a_q, alu_a_d;
  logic [ALU_W-1:0]  alu_b_q, alu_b_d;
  logic [CMD_W-1:0]  alu_cmd_q, alu_cmd_d;

  logic              rsp_fire;

  // A response completes when it is presented and the consumer takes it
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_hi_q    <= '0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_err_q   <= rsp_err_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
    end
  end

  // Next-state and next-output logic; ALU port registers are zero unless the
  // next state is an issue phase, so they are loaded on entry to ISSUE0/1
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rsp_valid_d = 1'b0;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_err_d   = rsp_err_q;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_cmd_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d = bus.req_op;
          if (!op_is_legal(bus.req_op) ||
              ((bus.req_op == OP_DIV) && (bus.req_b == '0))) begin
            // Rejected without touching the ALU
            rsp_err_d = 1'b1;
            rsp_lo_d  = '0;
            rsp_hi_d  = '0;
            state_d   = ST_RESP;
          end else begin
            rsp_err_d = 1'b0;
            if (op_swaps(bus.req_op)) begin
              alu_a_d = {bus.req_b, 1'b0};
              alu_b_d = {bus.req_a, 1'b0};
            end else begin
              alu_a_d = {bus.req_a, 1'b0};
              alu_b_d = {bus.req_b, 1'b0};
            end
            alu_cmd_d = op_to_cmd(bus.req_op);
            state_d   = ST_ISSUE0;
          end
        end
      end

      ST_ISSUE0: begin
        rsp_lo_d = bus.alu_res;
        if ((op_q == OP_MUL) || (op_q == OP_DIV)) begin
          // Second phase keeps the operands, switches to the hi-word command
          alu_a_d   = alu_a_q;
          alu_b_d   = alu_b_q;
          alu_cmd_d = (op_q == OP_MUL) ? CMD_MP1 : CMD_DV1;
          state_d   = ST_ISSUE1;
        end else begin
          rsp_hi_d = '0;
          state_d  = ST_RESP;
        end
      end

      ST_ISSUE1: begin
        rsp_hi_d = bus.alu_res;
        state_d  = ST_RESP;
      end

      ST_RESP: begin
        // Response word is registered, so rsp_valid rises one cycle after entry
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_lo      = rsp_lo_q;
  assign bus.rsp_hi      = rsp_hi_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_command = alu_cmd_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops_q;
  logic [15:0] perf_stall_q;

  // Completed-response counter wraps; stall counter saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (rsp_fire) begin
        perf_ops_q <= perf_ops_q + 16'd1;
      end
      if (rsp_valid_q && !bus.rsp_ready && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the command port.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  alu_op_sequencer_if bus();

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_ops;
  logic [15:0] perf_stall;
`endif

  alu_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: res = D op C, C from alu_a[15:1], D from alu_b[15:1]
  logic [14:0] alu_c, alu_d;
  logic [29:0] alu_prod;
  always_comb begin
    alu_c    = bus.alu_a[15:1];
    alu_d    = bus.alu_b[15:1];
    alu_prod = 30'(alu_d) * 30'(alu_c);
    case (bus.alu_command)
      3'd0:    bus.alu_res = alu_d + alu_c;
      3'd1:    bus.alu_res = alu_d - alu_c;
      3'd2:    bus.alu_res = alu_d & alu_c;
      3'd3:    bus.alu_res = alu_prod[14:0];
      3'd4:    bus.alu_res = alu_prod[29:15];
      3'd5:    bus.alu_res = (alu_c == 15'd0) ? 15'd0 : (alu_d % alu_c);
      3'd6:    bus.alu_res = (alu_c == 15'd0) ? 15'd0 : (alu_d / alu_c);
      default: bus.alu_res = 15'd0;
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [14:0] a;
    logic [14:0] b;
    logic [14:0] lo;
    logic [14:0] hi;
    logic        err;
    int          lat;
    logic [2:0]  cmd0;
    logic [2:0]  cmd1;
    logic [15:0] aa;
    logic [15:0] ab;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    int got;
    logic [15:0] exp_a1, exp_b1;

    //            op     a          b          lo          hi          err   lat cmd0  cmd1  alu_a       alu_b
    vecs[0]  = '{3'd0, 15'd5,     15'd7,     15'd12,     15'd0,      1'b0, 2, 3'd0, 3'd0, 16'h000A, 16'h000E};
    vecs[1]  = '{3'd1, 15'd10,    15'd3,     15'd7,      15'd0,      1'b0, 2, 3'd1, 3'd0, 16'h0006, 16'h0014};
    vecs[2]  = '{3'd2, 15'h0F0F,  15'h00FF,  15'h000F,   15'd0,      1'b0, 2, 3'd2, 3'd0, 16'h1E1E, 16'h01FE};
    vecs[3]  = '{3'd3, 15'd300,   15'd200,   15'd27232,  15'd1,      1'b0, 3, 3'd3, 3'd4, 16'h0258, 16'h0190};
    vecs[4]  = '{3'd4, 15'd100,   15'd7,     15'd2,      15'd14,     1'b0, 3, 3'd5, 3'd6, 16'h000E, 16'h00C8};
    vecs[5]  = '{3'd4, 15'd5,     15'd0,     15'd0,      15'd0,      1'b1, 1, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[6]  = '{3'd7, 15'd9,     15'd4,     15'd0,      15'd0,      1'b1, 1, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[7]  = '{3'd5, 15'd1,     15'd1,     15'd0,      15'd0,      1'b1, 1, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[8]  = '{3'd0, 15'h7FFF,  15'd1,     15'd0,      15'd0,      1'b0, 2, 3'd0, 3'd0, 16'hFFFE, 16'h0002};
    vecs[9]  = '{3'd1, 15'd3,     15'd10,    15'h7FF9,   15'd0,      1'b0, 2, 3'd1, 3'd0, 16'h0014, 16'h0006};
    vecs[10] = '{3'd3, 15'h7FFF,  15'h7FFF,  15'h0001,   15'h7FFE,   1'b0, 3, 3'd3, 3'd4, 16'hFFFE, 16'hFFFE};
    vecs[11] = '{3'd4, 15'd7,     15'd100,   15'd7,      15'd0,      1'b0, 3, 3'd5, 3'd6, 16'h00C8, 16'h000E};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values while reset is held
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_lo", 32'(bus.rsp_lo), 32'd0);
    check("reset rsp_hi", 32'(bus.rsp_hi), 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset alu_a", 32'(bus.alu_a), 32'd0);
    check("reset alu_b", 32'(bus.alu_b), 32'd0);
    check("reset alu_command", 32'(bus.alu_command), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      check($sformatf("v%0d req_ready idle", i), 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = vecs[i].op;
      bus.req_a     = vecs[i].a;
      bus.req_b     = vecs[i].b;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      // First issue phase (or nothing for rejected requests)
      check($sformatf("v%0d cmd0", i), 32'(bus.alu_command), 32'(vecs[i].cmd0));
      check($sformatf("v%0d alu_a", i), 32'(bus.alu_a), 32'(vecs[i].aa));
      check($sformatf("v%0d alu_b", i), 32'(bus.alu_b), 32'(vecs[i].ab));
      check($sformatf("v%0d req_ready busy", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("v%0d rsp_valid early", i), 32'(bus.rsp_valid), 32'd0);
      exp_a1 = (vecs[i].lat == 3) ? vecs[i].aa : 16'h0000;
      exp_b1 = (vecs[i].lat == 3) ? vecs[i].ab : 16'h0000;
      got = 0;
      for (int n = 1; n <= 8; n++) begin
        @(posedge clk);
        #1;
        if (n == 1 && !vecs[i].err) begin
          check($sformatf("v%0d cmd1", i), 32'(bus.alu_command), 32'(vecs[i].cmd1));
          check($sformatf("v%0d alu_a ph1", i), 32'(bus.alu_a), 32'(exp_a1));
          check($sformatf("v%0d alu_b ph1", i), 32'(bus.alu_b), 32'(exp_b1));
        end
        if (bus.rsp_valid) begin
          got = n;
          break;
        end
      end
      check($sformatf("v%0d latency", i), 32'(got), 32'(vecs[i].lat));
      check($sformatf("v%0d rsp_lo", i), 32'(bus.rsp_lo), 32'(vecs[i].lo));
      check($sformatf("v%0d rsp_hi", i), 32'(bus.rsp_hi), 32'(vecs[i].hi));
      check($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
      check($sformatf("v%0d alu idle in resp", i), 32'(bus.alu_command), 32'd0);
      $display("[TB] txn %0d op=%0d a=%0h b=%0h -> lo=%0h hi=%0h err=%0b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.rsp_lo, bus.rsp_hi, bus.rsp_err, got);
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      check($sformatf("v%0d rsp_valid drop", i), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("v%0d req_ready back", i), 32'(bus.req_ready), 32'd1);
    end

    // Backpressure: response held 5 cycles while a second request waits
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_a     = 15'd5;
    bus.req_b     = 15'd7;
    @(posedge clk);
    #1;
    bus.req_op    = 3'd3;
    bus.req_a     = 15'd300;
    bus.req_b     = 15'd200;
    got = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        got = n;
        break;
      end
    end
    check("bp latency", 32'(got), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_lo", c), 32'(bus.rsp_lo), 32'd12);
      check($sformatf("bp%0d rsp_hi", c), 32'(bus.rsp_hi), 32'd0);
      check($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 32'd0);
      check($sformatf("bp%0d alu_command", c), 32'(bus.alu_command), 32'd0);
    end
    $display("[TB] txn backpressure ADD held 5 cycles lo=%0h", bus.rsp_lo);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("bp rsp_valid drop", 32'(bus.rsp_valid), 32'd0);
    check("bp req_ready back", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("bp second not accepted", 32'(bus.req_ready), 32'd1);
    check("bp no issue", 32'(bus.alu_command), 32'd0);

    // Reset during ISSUE1 of a MUL
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_a     = 15'd300;
    bus.req_b     = 15'd200;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst in ISSUE1 cmd", 32'(bus.alu_command), 32'd4);
    reset = 1'b1;
    #1;
    check("rst abort req_ready", 32'(bus.req_ready), 32'd1);
    check("rst abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst abort rsp_lo", 32'(bus.rsp_lo), 32'd0);
    check("rst abort rsp_hi", 32'(bus.rsp_hi), 32'd0);
    check("rst abort rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst abort alu_a", 32'(bus.alu_a), 32'd0);
    check("rst abort alu_b", 32'(bus.alu_b), 32'd0);
    check("rst abort alu_command", 32'(bus.alu_command), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d no response", c), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("rst%0d idle", c), 32'(bus.req_ready), 32'd1);
    end
    $display("[TB] txn reset during MUL ISSUE1 aborted");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Front-end issuer that drives the ALU's command/operand port and captures its combinational `res`.
- Accepts operation requests over a valid/ready handshake and packs operands into the ALU's 16-bit operand format.
- For MUL it issues the MP0/MP1 command pair; for DIV it issues DV0/DV1. It then returns a two-word response (lo/hi) over a valid/ready handshake.
- Sits between the datapath controller and the ALU.

Parameters:
- OP_W, 3, request opcode width.
- DATA_W, 15, request operand and result word width (fixed by ALU width; not overridable in practice).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_op  input  3  0=ADD, 1=SUB, 2=AND, 3=MUL, 4=DIV, 5..7 illegal.
- req_a  input  15  operand A.
- req_b  input  15  operand B.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts response.
- rsp_lo  output  15  result / product[14:0] / remainder.
- rsp_hi  output  15  0 / product[29:15] / quotient.
- rsp_err  output  1  illegal op or divide-by-zero.
- alu_a  output  16  ALU operand A port ({operand,1'b0}).
- alu_b  output  16  ALU operand B port ({operand,1'b0}).
- alu_command  output  3  ALU command code.
- alu_res  input  15  ALU combinational result.

Behaviour:
- States: IDLE, ISSUE0, ISSUE1, RESP. Reset forces IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_err=0, alu_a=0, alu_b=0, alu_command=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b.
  - Illegal op, or DIV with req_b==0 → RESP with rsp_err=1, lo=hi=0.
  - Otherwise → ISSUE0.
- Operand mapping (ALU computes D op C, where C comes from alu_a and D from alu_b):
  - ADD/AND/MUL: alu_a={a,0}, alu_b={b,0}.
  - SUB and DIV: swapped, alu_a={b,0}, alu_b={a,0}, so the response is a-b or a/b.
  - Bit 0 is always driven 0.
- ISSUE0:
  - Drive command: ADD→0, SUB→1, AND→2, MUL→3 (MP0), DIV→5 (DV0).
  - At the clock edge, capture alu_res into lo.
  - MUL/DIV → ISSUE1; otherwise hi=0 → RESP.
- ISSUE1:
  - Keep operands and drive command 4 (MP1) or 6 (DV1).
  - At the edge, capture alu_res into hi → RESP.
- Outputs alu_a, alu_b and alu_command are registered. They are 0 outside ISSUE0/ISSUE1.
- RESP:
  - rsp_valid=1; lo/hi/err are stable until accepted.
  - On rsp_ready → IDLE, rsp_valid=0 next cycle.
  - No new request is accepted in the same cycle, so there is no simultaneous accept/respond.
- Latency, with the request accepted at edge k:
  - Single-phase op: rsp_valid high after edge k+2.
  - Two-phase op: rsp_valid high after edge k+3.
  - Error: rsp_valid high after edge k+1.
- Values are transported raw. Sign interpretation belongs to the ALU; the sequencer does no sign fixup.
- Reset mid-operation: immediate abort to IDLE, no response emitted, in-flight data discarded.
- req_valid while busy: ignored (req_ready=0). The requester must hold the request per handshake rules.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- When defined, adds two outputs:
  - perf_ops[15:0]: completed responses, wraps at 0xFFFF→0.
  - perf_stall[15:0]: cycles with rsp_valid&&!rsp_ready, saturating at 0xFFFF.
- Both counters reset to 0.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU command constants (ADD=0, SUB=1, AND=2, MP0=3, MP1=4, DV0=5, DV1=6);
  - the request opcode enum;
  - the state enum;
  - DATA_W.
- No sub-module is needed. The optional counters may live in alu_seq_perf when enabled.

Test Plan:
- ADD a=5, b=7 → alu_command=0, alu_a=16'h000A, alu_b=16'h000E; rsp_lo=12, rsp_hi=0, rsp_err=0, rsp_valid at k+2.
- SUB a=10, b=3 → alu_a=16'h0006, alu_b=16'h0014, alu_command=1; rsp_lo=7.
- MUL a=300, b=200 → commands 3 then 4 on consecutive cycles; rsp_lo=27232, rsp_hi=1, rsp_valid at k+3.
- DIV a=100, b=7 → commands 5 then 6; rsp_lo=2 (remainder), rsp_hi=14 (quotient).
- DIV b=0, and op=7 → no ALU issue (alu_command stays 0); rsp_err=1, lo=hi=0, rsp_valid at k+1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0, second request not accepted.
  - Assert reset during ISSUE1 → all outputs at reset values, no response.
